// File: rtl/apb_acc_sequencer_if.sv
// Bundles the sequencer's operand stream, result stream and APB signals.
// Modport master is the sequencer's view; modport slave is the view of the
// traffic source, result sink and APB slave taken together.
interface apb_acc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    // Operand stream: a transfer happens on a PCLK edge where s_valid && s_ready.
    // Result stream:  a transfer happens on a PCLK edge where r_valid && r_ready.
    // A source holds its payload stable while valid is high and not yet accepted.
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  s_valid, s_data, s_last, r_ready, PRDATA, PREADY, PSLVERR,
        output s_ready, r_valid, r_data, r_count, r_err,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output s_valid, s_data, s_last, r_ready, PRDATA, PREADY, PSLVERR,
        input  s_ready, r_valid, r_data, r_count, r_err,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_acc_sequencer.sv
// APB master feeding the OR-accumulator block: each operand becomes a DATA
// write followed by a CONTROL start write; the last operand of a batch adds a
// RESULT read whose value, operand count and error flag go out on r_*.
// Optional: define ACC_SEQ_TIMEOUT_EN to abandon ACCESS phases that see no
// PREADY within TIMEOUT cycles.
module apb_acc_sequencer #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] DATA_ADDR = 8'h00,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 8'h04,
    parameter logic [ADDR_W-1:0] RES_ADDR  = 8'h08,
    parameter int                CNT_W     = 8,
    parameter int                TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_acc_sequencer_if.master  bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {WR_DATA, WR_CTRL, RD_RES}   step_t;

    state_t            state, state_nxt;
    step_t             step, step_nxt;
    logic [DATA_W-1:0] op_data;
    logic              op_last;
    logic [DATA_W-1:0] r_data_q;
    logic [CNT_W-1:0]  r_count_q;
    logic              r_err_q;
    logic              r_valid_q;
    logic              xfer_done;
    logic              xfer_abandon;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

`ifdef ACC_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Count ACCESS cycles of the current transfer; cleared outside ACCESS.
    always_ff @(posedge PCLK) begin
        if (!PRESETn || state != ACCESS) tmo_cnt <= '0;
        else                             tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign xfer_abandon = (state == ACCESS) && !bus.PREADY &&
                          (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign xfer_abandon = 1'b0;
`endif

    // PREADY and PSLVERR only mean something during ACCESS.
    assign xfer_done = (state == ACCESS) && (bus.PREADY || xfer_abandon);

    // State and step registers.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
            step  <= WR_DATA;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next state and APB drive; bus lines are zero whenever PSEL is low.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        case (state)
            IDLE: begin
                if (bus.s_valid) begin
                    state_nxt = SETUP;
                    step_nxt  = WR_DATA;
                end
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (xfer_done) begin
                    case (step)
                        WR_DATA: begin
                            step_nxt  = WR_CTRL;
                            state_nxt = SETUP;
                        end
                        WR_CTRL: begin
                            if (op_last) begin
                                step_nxt  = RD_RES;
                                state_nxt = SETUP;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                        default: state_nxt = RESP;
                    endcase
                end
            end
            RESP: begin
                if (bus.r_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (psel) begin
            case (step)
                WR_DATA: begin
                    paddr  = DATA_ADDR;
                    pwrite = 1'b1;
                    pwdata = op_data;
                end
                WR_CTRL: begin
                    paddr  = CTRL_ADDR;
                    pwrite = 1'b1;
                    pwdata = DATA_W'(1);
                end
                default: paddr = RES_ADDR;
            endcase
        end
    end

    // Operand latch, batch counter, sticky error and result registers.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            op_data   <= '0;
            op_last   <= 1'b0;
            r_data_q  <= '0;
            r_count_q <= '0;
            r_err_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.s_valid) begin
                op_data   <= bus.s_data;
                op_last   <= bus.s_last;
                r_count_q <= r_count_q + 1'b1;
            end
            if (xfer_done) begin
                if ((bus.PREADY && bus.PSLVERR) || xfer_abandon) r_err_q <= 1'b1;
                if (step == RD_RES) begin
                    r_data_q  <= bus.PREADY ? bus.PRDATA : '0;
                    r_valid_q <= 1'b1;
                end
            end
            if (state == RESP && bus.r_ready) begin
                r_valid_q <= 1'b0;
                r_count_q <= '0;
                r_err_q   <= 1'b0;
            end
        end
    end

    assign bus.PSEL    = psel;
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite;
    assign bus.PADDR   = paddr;
    assign bus.PWDATA  = pwdata;
    assign bus.s_ready = (state == IDLE) && PRESETn;
    assign bus.r_valid = r_valid_q;
    assign bus.r_data  = r_data_q;
    assign bus.r_count = r_count_q;
    assign bus.r_err   = r_err_q;
    assign dbg_state   = state;

endmodule
